// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N stream demultiplexer with broadcast.
// Each output channel owns a one-entry register. An accepted input word is
// loaded into the selected channel, or into every channel in broadcast mode.
// A unicast word whose select is out of range is accepted and dropped, and a
// saturating counter records how many words were dropped.
module demux_stream_1xn #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic               drop_err,
    output logic [CNT_W-1:0]   drop_cnt
);

    // Channel count at select width plus one bit, so N == 2**SEL_W still fits.
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

    logic [N-1:0]       valid_q, valid_d;
    logic [N*WIDTH-1:0] data_q, data_d;
    logic               drop_err_q, drop_err_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [N-1:0]       free_s;
    logic               sel_ok_s;
    logic               sel_free_s;
    logic               accept_s;

    assign free_s   = ~valid_q | out_ready;
    assign sel_ok_s = ({1'b0, in_sel} < N_LIM);
    assign accept_s = in_valid & in_ready;

    // Look up the free flag of the selected channel without indexing past N-1.
    always_comb begin
        sel_free_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_free_s = free_s[k];
            end else begin
                sel_free_s = sel_free_s;
            end
        end
    end

    // Input ready: all channels free for broadcast, target free for unicast,
    // always ready for an out-of-range word (it is dropped), never in reset.
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &free_s;
        end else if (!sel_ok_s) begin
            in_ready = 1'b1;
        end else begin
            in_ready = sel_free_s;
        end
    end

    // Next channel state: drain on consumer transfer, then load addressed channels.
    always_comb begin
        valid_d = valid_q & ~out_ready;
        data_d  = data_q;
        for (int k = 0; k < N; k++) begin
            if (accept_s && (in_bcast || (sel_ok_s && (in_sel == SEL_W'(k))))) begin
                valid_d[k]                 = 1'b1;
                data_d[k*WIDTH +: WIDTH]   = in_data;
            end else begin
                valid_d[k]                 = valid_d[k];
            end
        end
    end

    // Next drop state: one-cycle error pulse and saturating drop count.
    always_comb begin
        drop_err_d = accept_s & ~in_bcast & ~sel_ok_s;
        if (drop_err_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers with synchronous reset that discards buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= {N{1'b0}};
            data_q     <= {(N*WIDTH){1'b0}};
            drop_err_q <= 1'b0;
            drop_cnt_q <= {CNT_W{1'b0}};
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drop_err  = drop_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Scoreboard bench for demux_stream_1xn (N=6, so selects 6 and 7 are out of range).
// The reference model is one FIFO of expected words per channel plus a drop counter.
module tb_demux_stream_1xn;

    localparam int W     = 8;
    localparam int N     = 6;
    localparam int SEL_W = 3;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [W-1:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               in_bcast;
    logic [N*W-1:0]     out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic               drop_err;
    logic [CNT_W-1:0]   drop_cnt;

    demux_stream_1xn #(.WIDTH(W), .N(N), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_err(drop_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] q[N][$];
    int           exp_cnt = 0;
    bit           exp_err = 1'b0;
    bit           mon_en  = 1'b0;
    int           n_cmp   = 0;
    int           n_err   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already set at the falling edge.
    task automatic cycle(output bit acc);
        bit exp_rdy;
        bit all_free;
        #1;
        all_free = 1'b1;
        for (int k = 0; k < N; k++)
            if (q[k].size() != 0 && !out_ready[k]) all_free = 1'b0;
        if (rst)                 exp_rdy = 1'b0;
        else if (in_bcast)       exp_rdy = all_free;
        else if (int'(in_sel) >= N) exp_rdy = 1'b1;
        else                     exp_rdy = (q[in_sel].size() == 0) || out_ready[in_sel];
        check("in_ready", in_ready, exp_rdy);
        acc = in_valid && exp_rdy;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) q[k].delete();
            exp_cnt = 0;
            exp_err = 1'b0;
        end else begin
            exp_err = acc && !in_bcast && (int'(in_sel) >= N);
            if (exp_err && exp_cnt != 65535) exp_cnt++;
            if (acc && in_bcast) begin
                for (int k = 0; k < N; k++) q[k].push_back(in_data);
            end else if (acc && int'(in_sel) < N) begin
                q[in_sel].push_back(in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    // Offer one word and wait (bounded) until it is accepted.
    task automatic send(input logic [W-1:0] d, input logic [SEL_W-1:0] s, input logic b);
        bit acc;
        int waited;
        in_data = d; in_sel = s; in_bcast = b; in_valid = 1'b1;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 64) begin
            cycle(acc);
            waited++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Monitor: compare presented outputs against the model and pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                for (int k = 0; k < N; k++) begin
                    if (q[k].size() != 0) begin
                        check("out_valid", out_valid[k], 1'b1);
                        check("out_data", out_data[k*W +: W], q[k][0]);
                        if (out_ready[k]) void'(q[k].pop_front());
                    end else begin
                        check("out_valid_idle", out_valid[k], 1'b0);
                    end
                end
                check("drop_err", drop_err, exp_err);
                check("drop_cnt", drop_cnt, 64'(exp_cnt));
            end
        end
    end

    initial begin
        bit acc;
        bit holding;
        int guard;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; in_sel = 3'd0; in_bcast = 1'b0;
        out_ready = {N{1'b1}};
        @(negedge clk);

        // T1: reset with in_valid high
        cycle(acc);
        mon_en = 1'b1;
        cycle(acc);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_valid", out_valid, 64'd0);
        rst = 1'b0;
        idle(1);

        // T2: back-to-back unicast stream, then the two out-of-range selects
        for (int i = 0; i < 8; i++) begin
            in_data = 8'h11 + 8'(i); in_sel = 3'(i); in_bcast = 1'b0; in_valid = 1'b1;
            cycle(acc);
        end
        idle(2);

        // T3: back-pressure on channel 3, refill on the draining edge
        out_ready = 6'b110111;
        send(8'hA5, 3'd3, 1'b0);
        in_data = 8'h5A; in_sel = 3'd3; in_bcast = 1'b0; in_valid = 1'b1;
        cycle(acc);
        cycle(acc);
        out_ready[3] = 1'b1;
        cycle(acc);
        check("t3_refill_acc", acc, 1'b1);
        idle(2);

        // T4: broadcast blocked by a full, stalled channel 5
        out_ready = 6'b011111;
        send(8'h77, 3'd5, 1'b0);
        in_data = 8'h3C; in_bcast = 1'b1; in_valid = 1'b1;
        cycle(acc);
        cycle(acc);
        out_ready[5] = 1'b1;
        cycle(acc);
        check("t4_bcast_valid", out_valid, 64'h3F);
        in_bcast = 1'b0;
        idle(2);

        // T5: drops leave channels untouched
        out_ready = {N{1'b0}};
        send(8'h42, 3'd2, 1'b0);
        in_data = 8'hEE; in_sel = 3'd7; in_bcast = 1'b0; in_valid = 1'b1;
        repeat (3) cycle(acc);
        idle(1);
        check("t5_drop_cnt", drop_cnt, 64'd5);
        check("t5_out_valid", out_valid, 64'h04);

        // T6: reset mid-operation discards stalled words
        send(8'h61, 3'd1, 1'b0);
        send(8'h64, 3'd4, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_out_valid", out_valid, 64'd0);
        out_ready = {N{1'b1}};
        idle(3);

        // Random traffic with producer hold rule and rare resets
        holding = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!holding) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
                in_sel   = SEL_W'($urandom_range(0, 7));
                in_bcast = ($urandom_range(0, 7) == 0);
            end
            out_ready = N'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            cycle(acc);
            holding = in_valid && !acc;
        end
        rst = 1'b0;
        idle(2);

        // Drive the drop counter into saturation and past it
        out_ready = {N{1'b1}};
        in_data = 8'hD0; in_sel = 3'd7; in_bcast = 1'b0; in_valid = 1'b1;
        guard = 0;
        while (exp_cnt != 65535 && guard < 70000) begin
            cycle(acc);
            guard++;
        end
        repeat (3) cycle(acc);
        idle(1);
        check("drop_sat", drop_cnt, 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
